// File: rtl/composer_pkg.sv
// Shared types and defaults for the composer datapath.
package composer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREVIEW,
        ST_PLAY_NOTE,
        ST_PLAY_GAP,
        ST_DONE
    } seq_state_t;

    localparam int unsigned REST       = 0;
    localparam int unsigned DEF_NOTE_W = 8;
    localparam int unsigned DEF_DEPTH  = 64;
    localparam int unsigned DEF_DUR_W  = 24;

endpackage

// File: rtl/note_timer.sv
// Loadable down-counter; expired_o marks the last enabled cycle of a loaded interval.
module note_timer
    import composer_pkg::*;
#(
    parameter int unsigned DUR_W = DEF_DUR_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic [DUR_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             expired_o
);

    logic [DUR_W-1:0] cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expired_o = en_i && (cnt_q == DUR_W'(1));

endmodule

// File: rtl/note_sequencer.sv
// Note store with insert preview and in-order (optionally looping) playback.
module note_sequencer
    import composer_pkg::*;
#(
    parameter int unsigned NOTE_W     = DEF_NOTE_W,
    parameter int unsigned DEPTH      = DEF_DEPTH,
    parameter int unsigned DUR_W      = DEF_DUR_W,
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       key_valid,
    input  logic [NOTE_W-1:0]          key_code,
    input  logic                       insert_en,
    input  logic                       delete_en,
    input  logic                       play_start,
    input  logic                       play_stop,
    input  logic                       loop,
    input  logic [DUR_W-1:0]           note_dur,
    output logic [NOTE_W-1:0]          note_out,
    output logic                       note_valid,
    output logic                       busy,
    output logic                       insert_done,
    output logic                       play_done,
    output logic                       err,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    seq_state_t        state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [IDX_W-1:0]  idx_q, idx_d, rd_idx;
    logic [NOTE_W-1:0] note_q, note_d;
    logic              from_play_q, from_play_d;
    logic              note_valid_q, busy_q, insert_done_q, play_done_q, err_q, full_q, empty_q;
    logic              err_d, wr_en, note_load, gap_load, advance;
    logic              note_exp, gap_exp, is_full, is_empty, last;
    logic [DUR_W-1:0]  dur_eff;
    logic [NOTE_W-1:0] mem_q [DEPTH];

    assign is_full  = (count_q == CNT_W'(DEPTH));
    assign is_empty = (count_q == '0);
    assign last     = ((CNT_W'(idx_q) + 1'b1) == count_q);
    assign dur_eff  = (note_dur == '0) ? DUR_W'(1) : note_dur;

    note_timer #(.DUR_W(DUR_W)) u_note_timer (
        .clock      (clock),
        .reset      (reset),
        .load_i     (note_load),
        .load_val_i (dur_eff),
        .en_i       ((state_q == ST_PREVIEW) || (state_q == ST_PLAY_NOTE)),
        .expired_o  (note_exp)
    );

    note_timer #(.DUR_W(DUR_W)) u_gap_timer (
        .clock      (clock),
        .reset      (reset),
        .load_i     (gap_load),
        .load_val_i (DUR_W'(GAP_CYCLES)),
        .en_i       (state_q == ST_PLAY_GAP),
        .expired_o  (gap_exp)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        idx_d       = idx_q;
        note_d      = note_q;
        from_play_d = from_play_q;
        rd_idx      = '0;
        err_d       = 1'b0;
        wr_en       = 1'b0;
        note_load   = 1'b0;
        gap_load    = 1'b0;
        advance     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (play_start) begin
                    from_play_d = 1'b1;
                    if (is_empty) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d     = '0;
                        note_d    = mem_q[rd_idx];
                        note_load = 1'b1;
                        state_d   = ST_PLAY_NOTE;
                    end
                end else if (insert_en && key_valid) begin
                    if (is_full) begin
                        err_d = 1'b1;
                    end else begin
                        wr_en       = 1'b1;
                        count_d     = count_q + 1'b1;
                        note_d      = key_code;
                        note_load   = 1'b1;
                        from_play_d = 1'b0;
                        state_d     = ST_PREVIEW;
                    end
                end else if (delete_en) begin
                    if (is_empty) err_d = 1'b1;
                    else          count_d = count_q - 1'b1;
                end
            end
            ST_PREVIEW: begin
                if (play_stop)     state_d = ST_IDLE;
                else if (note_exp) state_d = ST_DONE;
            end
            ST_PLAY_NOTE: begin
                if (play_stop) begin
                    state_d = ST_IDLE;
                end else if (note_exp) begin
                    if (GAP_CYCLES > 0) begin
                        gap_load = 1'b1;
                        state_d  = ST_PLAY_GAP;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            ST_PLAY_GAP: begin
                if (play_stop)    state_d = ST_IDLE;
                else if (gap_exp) advance = 1'b1;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Shared by note expiry (no gap) and gap expiry: next note, wrap, or finish.
        if (advance) begin
            rd_idx = last ? '0 : idx_q + 1'b1;
            if (!last || loop) begin
                idx_d     = rd_idx;
                note_d    = mem_q[rd_idx];
                note_load = 1'b1;
                state_d   = ST_PLAY_NOTE;
            end else begin
                state_d = ST_DONE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) mem_q[IDX_W'(count_q)] <= key_code;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            count_q       <= '0;
            idx_q         <= '0;
            note_q        <= NOTE_W'(REST);
            from_play_q   <= 1'b0;
            note_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
            insert_done_q <= 1'b0;
            play_done_q   <= 1'b0;
            err_q         <= 1'b0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            idx_q         <= idx_d;
            note_q        <= note_d;
            from_play_q   <= from_play_d;
            note_valid_q  <= (state_d == ST_PREVIEW) || (state_d == ST_PLAY_NOTE);
            busy_q        <= (state_d != ST_IDLE);
            insert_done_q <= (state_d == ST_DONE) && !from_play_d;
            play_done_q   <= (state_d == ST_DONE) && from_play_d;
            err_q         <= err_d;
            full_q        <= (count_d == CNT_W'(DEPTH));
            empty_q       <= (count_d == '0);
        end
    end

    assign note_out    = note_q;
    assign note_valid  = note_valid_q;
    assign busy        = busy_q;
    assign insert_done = insert_done_q;
    assign play_done   = play_done_q;
    assign err         = err_q;
    assign count       = count_q;
    assign full        = full_q;
    assign empty       = empty_q;

endmodule
